// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer: 640x480@60 VGA timing with a 40x30 map of 16x16 tiles.
// Tile words come from video RAM port B and a player marker is overlaid.
// Ports:
//   clk, rst                  pixel clock (25 MHz), synchronous active-high reset
//   player_tx/ty/color        player tile position and colour, latched per frame
//   addrb / doutb             video RAM port-B word address / read data
//   hs, vs                    active-low sync outputs
//   red, green, blue          4:4:4 pixel colour
//   frame_start               high while the counters sit at (0,0)
module vga_tile_renderer #(
   parameter int          H_VIS    = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_VIS    = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33,
   parameter logic [13:0] MAP_BASE = 14'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  player_tx,
   input  logic [4:0]  player_ty,
   input  logic [11:0] player_color,
   output logic [13:0] addrb,
   input  logic [31:0] doutb,
   output logic        hs,
   output logic        vs,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic        frame_start
);

   localparam logic [9:0] H_MAX  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_MAX  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VISC = 10'(H_VIS);
   localparam logic [9:0] V_VISC = 10'(V_VIS);
   localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);

   // counters
   logic [9:0]  h_q, h_d;
   logic [9:0]  v_q, v_d;
   // per-frame player latch
   logic [5:0]  ptx_q, ptx_d;
   logic [4:0]  pty_q, pty_d;
   logic [11:0] pcol_q, pcol_d;
   // stage 1
   logic [13:0] addr_q, addr_d;
   logic        de1_q, de1_d;
   logic        hs1_q, hs1_d;
   logic        vs1_q, vs1_d;
   logic [3:0]  px1_q, px1_d;
   logic [3:0]  py1_q, py1_d;
   logic        hit1_q, hit1_d;
   // stage 2
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic [11:0] rgb_q, rgb_d;

   logic [5:0]  tx;
   logic [4:0]  ty;
   logic [3:0]  px;
   logic [3:0]  py;
   logic [13:0] ty_w;
   logic        p_in_range;
   logic        unused_bits;

   assign unused_bits = ^doutb[31:13];

   always_comb begin
      h_d         = h_q;
      v_d         = v_q;
      ptx_d       = ptx_q;
      pty_d       = pty_q;
      pcol_d      = pcol_q;
      frame_start = 1'b0;

      if (!rst && h_q == 10'd0 && v_q == 10'd0) begin
         frame_start = 1'b1;
      end

      if (h_q == H_MAX) begin
         h_d = 10'd0;
         v_d = (v_q == V_MAX) ? 10'd0 : v_q + 10'd1;
      end else begin
         h_d = h_q + 10'd1;
      end

      // player inputs are only taken at the top of a frame, so no tearing
      if (frame_start) begin
         ptx_d  = player_tx;
         pty_d  = player_ty;
         pcol_d = player_color;
      end
   end

   always_comb begin
      tx   = h_q[9:4];
      ty   = v_q[8:4];
      px   = h_q[3:0];
      py   = v_q[3:0];
      ty_w = {9'd0, ty};

      // ty*40 as (ty<<5)+(ty<<3); wraps mod 2^14
      addr_d = MAP_BASE + (ty_w << 5) + (ty_w << 3) + {8'd0, tx};

      de1_d = (h_q < H_VISC) && (v_q < V_VISC);
      hs1_d = !((h_q >= HS_BEG) && (h_q <= HS_END));
      vs1_d = !((v_q >= VS_BEG) && (v_q <= VS_END));
      px1_d = px;
      py1_d = py;

      p_in_range = (ptx_q < 6'd40) && (pty_q < 5'd30);
      hit1_d     = p_in_range && (tx == ptx_q) && (ty == pty_q)
                && (px >= 4'd2) && (px <= 4'd13)
                && (py >= 4'd2) && (py <= 4'd13);
   end

   always_comb begin
      hs_d  = hs1_q;
      vs_d  = vs1_q;
      rgb_d = doutb[11:0];
      if (!de1_q) begin
         rgb_d = 12'h000;
      end else if (hit1_q) begin
         rgb_d = pcol_q;
      end else if (doutb[12] && (px1_q == 4'd0 || py1_q == 4'd0)) begin
         rgb_d = 12'hFFF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_q    <= 10'd0;
         v_q    <= 10'd0;
         ptx_q  <= 6'h3F;
         pty_q  <= 5'h1F;
         pcol_q <= 12'h000;
         addr_q <= MAP_BASE;
         de1_q  <= 1'b0;
         hs1_q  <= 1'b1;
         vs1_q  <= 1'b1;
         px1_q  <= 4'd0;
         py1_q  <= 4'd0;
         hit1_q <= 1'b0;
         hs_q   <= 1'b1;
         vs_q   <= 1'b1;
         rgb_q  <= 12'h000;
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         ptx_q  <= ptx_d;
         pty_q  <= pty_d;
         pcol_q <= pcol_d;
         addr_q <= addr_d;
         de1_q  <= de1_d;
         hs1_q  <= hs1_d;
         vs1_q  <= vs1_d;
         px1_q  <= px1_d;
         py1_q  <= py1_d;
         hit1_q <= hit1_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         rgb_q  <= rgb_d;
      end
   end

   assign addrb = addr_q;
   assign hs    = hs_q;
   assign vs    = vs_q;
   assign red   = rgb_q[11:8];
   assign green = rgb_q[7:4];
   assign blue  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_tile_renderer.sv
// tb_vga_tile_renderer: directed bench for vga_tile_renderer with a
// pixel-level reference model and literal spot checks.
module tb_vga_tile_renderer;

   localparam int H_TOT = 800;
   localparam int VV    = 20;
   localparam int VFP   = 1;
   localparam int VSW   = 2;
   localparam int VBP   = 1;
   localparam int V_TOT = VV + VFP + VSW + VBP;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic [11:0] rgb;
   } pins_t;

   localparam pins_t RST_PINS = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};

   logic        clk;
   logic        rst;
   logic [5:0]  player_tx;
   logic [4:0]  player_ty;
   logic [11:0] player_color;
   logic [13:0] addrb, addrb2;
   logic [31:0] doutb, doutb2;
   logic        hs, vs, hs2, vs2;
   logic [3:0]  red, green, blue;
   logic [3:0]  red2, green2, blue2;
   logic        frame_start, frame_start2;

   logic [31:0] mem [0:16383];

   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   int    mh     = 0;
   int    mv     = 0;
   int    m_ptx  = 63;
   int    m_pty  = 31;
   logic [11:0] m_pcol = 12'h000;
   pins_t p1, p2;
   logic [13:0] m_addr;
   logic  model_on = 1'b0;

   vga_tile_renderer #(
      .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
   ) u_dut (
      .clk(clk), .rst(rst),
      .player_tx(player_tx), .player_ty(player_ty),
      .player_color(player_color),
      .addrb(addrb), .doutb(doutb),
      .hs(hs), .vs(vs),
      .red(red), .green(green), .blue(blue),
      .frame_start(frame_start)
   );

   vga_tile_renderer #(
      .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .MAP_BASE(14'h100)
   ) u_dut2 (
      .clk(clk), .rst(rst),
      .player_tx(player_tx), .player_ty(player_ty),
      .player_color(player_color),
      .addrb(addrb2), .doutb(doutb2),
      .hs(hs2), .vs(vs2),
      .red(red2), .green(green2), .blue(blue2),
      .frame_start(frame_start2)
   );

   // asynchronous-read RAM: data settles within the cycle after addrb
   assign doutb  = mem[addrb];
   assign doutb2 = mem[addrb2 - 14'h100];

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // what a pixel at counter (h,v) must look like on the pins
   function automatic pins_t model_pix(int h, int v, int ptx, int pty,
                                       logic [11:0] pcol);
      pins_t r;
      logic [31:0] w;
      int tx, ty, px, py;
      tx = h / 16;
      ty = v / 16;
      px = h % 16;
      py = v % 16;
      w  = mem[(ty * 40 + tx) % 16384];
      r.hs = !(h >= 656 && h < 752);
      r.vs = !(v >= VV + VFP && v < VV + VFP + VSW);
      if (!(h < 640 && v < VV))
         r.rgb = 12'h000;
      else if (ptx < 40 && pty < 30 && tx == ptx && ty == pty &&
               px >= 2 && px <= 13 && py >= 2 && py <= 13)
         r.rgb = pcol;
      else if (w[12] && (px == 0 || py == 0))
         r.rgb = 12'hFFF;
      else
         r.rgb = w[11:0];
      return r;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         mh       <= 0;
         mv       <= 0;
         p1       <= RST_PINS;
         p2       <= RST_PINS;
         m_addr   <= 14'h000;
         model_on <= 1'b1;
      end else begin
         p2     <= p1;
         p1     <= model_pix(mh, mv, m_ptx, m_pty, m_pcol);
         m_addr <= 14'((mv / 16) * 40 + mh / 16);
         if (mh == 0 && mv == 0) begin
            m_ptx  <= int'(player_tx);
            m_pty  <= int'(player_ty);
            m_pcol <= player_color;
         end
         if (mh == H_TOT - 1) begin
            mh <= 0;
            mv <= (mv == V_TOT - 1) ? 0 : mv + 1;
         end else begin
            mh <= mh + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("pins", {18'd0, hs, vs, red, green, blue},
               {18'd0, p2.hs, p2.vs, p2.rgb});
         check("pins_base100", {18'd0, hs2, vs2, red2, green2, blue2},
               {18'd0, p2.hs, p2.vs, p2.rgb});
         check("addrb", {4'd0, addrb, addrb2},
               {4'd0, m_addr, m_addr + 14'h100});
         check("frame_start", {30'd0, frame_start, frame_start2},
               {30'd0, {2{!rst && mh == 0 && mv == 0}}});
      end
   end

   // sync period / width and one frame_start per frame
   logic hs_prev = 1'b1;
   logic vs_prev = 1'b1;
   int   hs_fall = -1;
   int   vs_fall = -1;
   int   fs_cnt  = 0;

   always @(negedge clk) begin
      if (rst) begin
         hs_fall = -1;
         vs_fall = -1;
         fs_cnt  = 0;
         hs_prev = 1'b1;
         vs_prev = 1'b1;
      end else if (model_on) begin
         if (frame_start) fs_cnt++;
         if (hs_prev && !hs) begin
            if (hs_fall >= 0) check("hs_period", cyc - hs_fall, 800);
            hs_fall = cyc;
         end
         if (!hs_prev && hs && hs_fall >= 0)
            check("hs_low", cyc - hs_fall, 96);
         if (vs_prev && !vs) begin
            if (vs_fall >= 0) begin
               check("vs_period", cyc - vs_fall, H_TOT * V_TOT);
               check("fs_per_frame", fs_cnt, 1);
            end
            vs_fall = cyc;
            fs_cnt  = 0;
         end
         if (!vs_prev && vs && vs_fall >= 0)
            check("vs_low", cyc - vs_fall, 1600);
         hs_prev = hs;
         vs_prev = vs;
      end
   end

   task automatic wait_cnt(input int h, input int v);
      int i;
      for (i = 0; i < 30000; i++) begin
         if (mh == h && mv == v) break;
         @(negedge clk);
      end
      if (i >= 30000) begin
         checks++;
         errors++;
         $display("FAIL timeout waiting for counters %0d,%0d", h, v);
      end
   endtask

   // pixel (h,v) reaches the pins two clocks after the counters
   task automatic check_pix(input int h, input int v, input logic [11:0] exp);
      wait_cnt(h + 2, v);
      check($sformatf("pix_%0d_%0d", h, v), {20'd0, red, green, blue},
            {20'd0, exp});
   endtask

   task automatic first_hs_fall();
      int n;
      n = 0;
      for (int i = 1; i <= 2000; i++) begin
         @(negedge clk);
         if (i == 1)
            check("post_release", {19'd0, hs, vs, red, green, blue},
                  {19'd0, 2'b11, 12'h000});
         if (!hs) begin
            n = i;
            break;
         end
      end
      check("first_hs_fall", n, 658);
   endtask

   initial begin
      for (int i = 0; i < 16384; i++)
         mem[i] = (i * 37) & 32'h0000_1FFF;
      mem[0]  = 32'h0000_1F00;
      mem[1]  = 32'hFFFF_E123;
      mem[42] = 32'h0000_0456;
      mem[43] = 32'h0000_0789;

      rst          = 1'b1;
      player_tx    = 6'd2;
      player_ty    = 5'd1;
      player_color = 12'h0F0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sync", {30'd0, hs, vs}, 32'd3);
      check("rst_rgb", {20'd0, red, green, blue}, 32'h000);
      check("rst_addrb", {18'd0, addrb}, 32'h000);
      check("rst_addrb2", {18'd0, addrb2}, 32'h100);
      check("rst_fs", {31'd0, frame_start}, 32'd0);
      rst = 1'b0;

      first_hs_fall();

      // frame 1
      check_pix(1, 1, 12'hF00);
      check_pix(0, 5, 12'hFFF);
      check_pix(16, 1, 12'h123);
      wait_cnt(17, 16);
      check("addr_16_16", {18'd0, addrb}, 32'd41);
      check("addr2_16_16", {18'd0, addrb2}, 32'h100 + 32'd41);
      check_pix(32, 18, 12'h456);
      check_pix(34, 18, 12'h0F0);
      check_pix(47, 18, 12'h456);
      player_tx    = 6'd3;
      player_color = 12'h00F;
      check_pix(34, 19, 12'h0F0);
      check_pix(50, 19, 12'h789);
      wait_cnt(0, 21);
      mem[0] = 32'h0000_0F00;

      // frame 2
      check_pix(0, 5, 12'hF00);
      check_pix(34, 18, 12'h456);
      check_pix(50, 18, 12'h00F);
      player_tx    = 6'd45;
      player_color = 12'hFFF;

      // frame 3: reset mid-line
      wait_cnt(300, 10);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_sync", {30'd0, hs, vs}, 32'd3);
      check("mid_rst_rgb", {20'd0, red, green, blue}, 32'h000);
      check("mid_rst_addrb", {18'd0, addrb}, 32'h000);
      check("mid_rst_fs", {31'd0, frame_start}, 32'd0);
      rst = 1'b0;
      first_hs_fall();
      repeat (200) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
